// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters, the arbiter and the uart transmit pins.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 uart_transmit;
    logic [7:0]           uart_tx_byte;
    logic                 uart_is_transmitting;

    modport slave (
        input  req_valid, req_data, req_last, uart_is_transmitting,
        output req_ready, grant, busy, uart_transmit, uart_tx_byte
    );

    modport master (
        output req_valid, req_data, req_last, uart_is_transmitting,
        input  req_ready, grant, busy, uart_transmit, uart_tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart transmitter among NUM_REQ byte streams.
// A grant is held until a byte with req_last=1 completes or the owner stalls for LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned OW = $clog2(NUM_REQ);
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] owner, owner_nxt;
    logic [OW-1:0] last_owner, last_owner_nxt;
    logic          last_flag, last_flag_nxt;
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;

    logic [OW-1:0] pick;
    logic [OW-1:0] scan_idx;
    logic          pick_vld;

    // First valid requester scanning upward from the one after last_owner, with wrap
    always_comb begin : rr_pick
        pick     = '0;
        pick_vld = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = OW'((32'(last_owner) + i) % NUM_REQ);
            if (!pick_vld && bus.req_valid[scan_idx]) begin
                pick     = scan_idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            last_flag  <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            last_flag  <= last_flag_nxt;
            lock_cnt   <= lock_cnt_nxt;
        end
    end

    always_comb begin : next_and_out
        state_nxt         = state;
        owner_nxt         = owner;
        last_owner_nxt    = last_owner;
        last_flag_nxt     = last_flag;
        lock_cnt_nxt      = lock_cnt;
        bus.req_ready     = '0;
        bus.grant         = '0;
        bus.busy          = (state != IDLE);
        bus.uart_transmit = 1'b0;
        bus.uart_tx_byte  = 8'h00;

        if (state != IDLE) begin
            bus.grant = NUM_REQ'(1) << owner;
        end

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    owner_nxt    = pick;
                    lock_cnt_nxt = '0;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                bus.req_ready[owner] = !bus.uart_is_transmitting;
                if (bus.req_valid[owner] && !bus.uart_is_transmitting) begin
                    bus.uart_transmit = 1'b1;
                    bus.uart_tx_byte  = bus.req_data[{owner, 3'b000} +: 8];
                    last_flag_nxt     = bus.req_last[owner];
                    state_nxt         = WAIT_BUSY;
                end else begin
                    if (lock_cnt != '1) begin
                        lock_cnt_nxt = lock_cnt + CW'(1);
                    end
                    // Stalled owner loses the grant and re-arbitrates at lowest priority
                    if ((LOCK_TIMEOUT != 0) && (lock_cnt == LOCK_LAST)) begin
                        last_owner_nxt = owner;
                        state_nxt      = IDLE;
                    end
                end
            end
            WAIT_BUSY: begin
                if (bus.uart_is_transmitting) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_is_transmitting) begin
                    if (last_flag) begin
                        last_owner_nxt = owner;
                        state_nxt      = IDLE;
                    end else begin
                        lock_cnt_nxt = '0;
                        state_nxt    = SEND;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues, a 20-cycle uart model and
// a transmit log, checked with immediate assertions against hand-computed values.
module tb_uart_tx_arbiter;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b1;
    logic force_busy = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Requester byte queues: {last, data}
    logic [8:0] mem [N][16];
    int head [N];
    int tail [N];

    always_comb begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i]) begin
                bus.req_valid[i]      = 1'b1;
                bus.req_data[8*i +: 8] = mem[i][head[i] % 16][7:0];
                bus.req_last[i]       = mem[i][head[i] % 16][8];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (flush) head[i] <= tail[i];
            else if (bus.req_valid[i] && bus.req_ready[i]) head[i] <= head[i] + 1;
        end
    end

    // Uart model: busy rises the cycle after transmit and stays high 20 cycles
    int tx_cnt = 0;
    always @(posedge clk) begin
        if (rst) tx_cnt <= 0;
        else if (bus.uart_transmit) tx_cnt <= 20;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign bus.uart_is_transmitting = (tx_cnt != 0) || force_busy;

    logic [7:0] log_byte  [64];
    logic [3:0] log_grant [64];
    int         n_log = 0;
    always @(posedge clk) begin
        if (!rst && bus.uart_transmit) begin
            log_byte[n_log % 64]  <= bus.uart_tx_byte;
            log_grant[n_log % 64] <= bus.grant;
            n_log <= n_log + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic last, input logic [7:0] d);
        mem[r][tail[r] % 16] = {last, d};
        tail[r]++;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        tick();
    endtask

    task automatic wait_log(input string tag, input int target, input int budget);
        for (int k = 0; k < budget && n_log < target; k++) tick();
        chk(tag, n_log, target);
    endtask

    task automatic wait_tx_low(input string tag);
        for (int k = 0; k < 100 && bus.uart_is_transmitting; k++) tick();
        chk(tag, 32'(bus.uart_is_transmitting), 0);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 200 && bus.busy; k++) tick();
        chk(tag, 32'(bus.busy), 0);
    endtask

    int base;

    initial begin
        // Reset state
        do_reset();
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_transmit", bus.uart_transmit, 0);
        chk("rst_byte", bus.uart_tx_byte, 0);

        // Single byte from req0
        base = n_log;
        push(0, 1'b1, 8'h55);
        chk("t1_idle_ready", bus.req_ready, 0);
        tick();
        chk("t1_grant", bus.grant, 4'b0001);
        chk("t1_ready", bus.req_ready, 4'b0001);
        chk("t1_transmit", bus.uart_transmit, 1);
        chk("t1_byte", bus.uart_tx_byte, 8'h55);
        tick();
        chk("t1_after_transmit", bus.uart_transmit, 0);
        chk("t1_after_ready", bus.req_ready, 0);
        wait_tx_low("t1_tx_fall");
        chk("t1_grant_held", bus.grant, 4'b0001);
        tick();
        chk("t1_grant_idle", bus.grant, 0);
        chk("t1_busy_idle", bus.busy, 0);
        chk("t1_one_pulse", n_log, base + 1);

        // Two 3-byte packets from req0 and req2
        do_reset();
        base = n_log;
        push(0, 1'b0, 8'hA0); push(0, 1'b0, 8'hA1); push(0, 1'b1, 8'hA2);
        push(2, 1'b0, 8'hC0); push(2, 1'b0, 8'hC1); push(2, 1'b1, 8'hC2);
        wait_log("t2_a2_sent", base + 3, 200);
        chk("t2_grant_after_a2", bus.grant, 4'b0001);
        wait_tx_low("t2_a2_fall");
        chk("t2_grant_a2_done", bus.grant, 4'b0001);
        wait_log("t2_c2_sent", base + 6, 200);
        chk("t2_b0", log_byte[(base + 0) % 64], 8'hA0);
        chk("t2_b1", log_byte[(base + 1) % 64], 8'hA1);
        chk("t2_b2", log_byte[(base + 2) % 64], 8'hA2);
        chk("t2_b3", log_byte[(base + 3) % 64], 8'hC0);
        chk("t2_b4", log_byte[(base + 4) % 64], 8'hC1);
        chk("t2_b5", log_byte[(base + 5) % 64], 8'hC2);
        chk("t2_g2", log_grant[(base + 2) % 64], 4'b0001);
        chk("t2_g3", log_grant[(base + 3) % 64], 4'b0100);
        chk("t2_g5", log_grant[(base + 5) % 64], 4'b0100);
        wait_idle("t2_idle");

        // All four requesters with 1-byte packets: round-robin order
        do_reset();
        base = n_log;
        for (int r = 0; r < 4; r++) begin
            push(r, 1'b1, 8'(8'h10 + r));
            push(r, 1'b1, 8'(8'h20 + r));
        end
        wait_log("t3_sent", base + 8, 400);
        chk("t3_g0", log_grant[(base + 0) % 64], 4'b0001);
        chk("t3_g1", log_grant[(base + 1) % 64], 4'b0010);
        chk("t3_g2", log_grant[(base + 2) % 64], 4'b0100);
        chk("t3_g3", log_grant[(base + 3) % 64], 4'b1000);
        chk("t3_g4", log_grant[(base + 4) % 64], 4'b0001);
        chk("t3_g5", log_grant[(base + 5) % 64], 4'b0010);
        chk("t3_b4", log_byte[(base + 4) % 64], 8'h20);
        wait_idle("t3_idle");

        // Lock timeout: req1 stalls mid-packet while req3 waits
        do_reset();
        base = n_log;
        push(1, 1'b0, 8'hAA);
        push(3, 1'b1, 8'h33);
        tick();
        chk("t4_grant", bus.grant, 4'b0010);
        chk("t4_byte", bus.uart_tx_byte, 8'hAA);
        tick();
        wait_tx_low("t4_tx_fall");
        tick();
        chk("t4_send_grant", bus.grant, 4'b0010);
        chk("t4_send_ready", bus.req_ready, 4'b0010);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("t4_hold_grant", bus.grant, 4'b0010);
        end
        tick();
        chk("t4_released", bus.grant, 0);
        chk("t4_released_busy", bus.busy, 0);
        tick();
        chk("t4_req3_grant", bus.grant, 4'b1000);
        chk("t4_req3_transmit", bus.uart_transmit, 1);
        chk("t4_req3_byte", bus.uart_tx_byte, 8'h33);
        wait_idle("t4_idle");

        // Reset while in WAIT_DONE
        push(2, 1'b1, 8'h77);
        tick();
        chk("t5_grant", bus.grant, 4'b0100);
        tick();
        tick();
        tick();
        chk("t5_in_frame", bus.busy, 1);
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        chk("t5_rst_grant", bus.grant, 0);
        chk("t5_rst_ready", bus.req_ready, 0);
        chk("t5_rst_transmit", bus.uart_transmit, 0);
        chk("t5_rst_busy", bus.busy, 0);
        rst   = 1'b0;
        flush = 1'b0;
        tick();
        push(0, 1'b1, 8'h44);
        push(1, 1'b1, 8'h45);
        tick();
        chk("t5_req0_first", bus.grant, 4'b0001);
        chk("t5_req0_byte", bus.uart_tx_byte, 8'h44);
        base = n_log;
        wait_log("t5_both_sent", base + 2, 200);
        chk("t5_second", log_grant[(base + 1) % 64], 4'b0010);
        wait_idle("t5_idle");

        // Uart externally busy while req0 holds SEND
        force_busy = 1'b1;
        push(0, 1'b1, 8'h66);
        base = n_log;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_grant", bus.grant, 4'b0001);
            chk("t6_ready", bus.req_ready, 0);
            chk("t6_transmit", bus.uart_transmit, 0);
        end
        force_busy = 1'b0;
        #1;
        chk("t6_ready_low", bus.req_ready, 4'b0001);
        chk("t6_transmit_low", bus.uart_transmit, 1);
        chk("t6_byte", bus.uart_tx_byte, 8'h66);
        tick();
        chk("t6_logged", n_log, base + 1);
        wait_idle("t6_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
